seg_scan_controller: RTL and testbench

//  Time-multiplexes one shared active-low 7-segment bus across NUM_DIGITS common-anode digits.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_hex_decode.sv | 13 +
 rtl/seg_scan_controller.sv | 156 +++++++++++++++
 tb/tb_seg_scan_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Indexed by nibble value; entry 15 (F) is leftmost.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = HEX_GLYPHS[nibble_i];
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Scans NUM_DIGITS common-anode digits over one shared active-low segment bus,
// with a blanking guard per slot and a per-frame input snapshot.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SCAN_HZ    = 8_000,
  parameter int unsigned BLANK_CYC  = 64,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [7:0]              AN,
  output logic                    frame_done
);

  localparam int unsigned SLOT  = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e              state_q, state_d;
  logic [CNT_W-1:0]         slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     snap_load;
  logic [4*NUM_DIGITS-1:0]  snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]    snap_en_q, snap_en_d;
  logic [NUM_DIGITS-1:0]    snap_dp_q, snap_dp_d;
  logic [7:0]               an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_q, dp_d;
  logic                     frame_done_q, frame_done_d;
  logic [3:0]               dec_nibble;
  logic [6:0]               dec_glyph;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    snap_load    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = BLANK;
          slot_cnt_d = '0;
          idx_d      = '0;
          snap_load  = 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d    = IDLE;
          slot_cnt_d = '0;
          idx_d      = '0;
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
          if (slot_cnt_q == BLANK_LAST) state_d = SHOW;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d    = IDLE;
          slot_cnt_d = '0;
          idx_d      = '0;
        end else if (slot_cnt_q == SLOT_LAST) begin
          state_d    = BLANK;
          slot_cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            snap_load    = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        slot_cnt_d = '0;
        idx_d      = '0;
      end
    endcase
  end

  always_comb begin
    snap_digits_d = snap_load ? digits_i   : snap_digits_q;
    snap_en_d     = snap_load ? digit_en_i : snap_en_q;
    snap_dp_d     = snap_load ? dp_i       : snap_dp_q;
  end

  assign dec_nibble = snap_digits_d[{idx_d, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nibble_i (dec_nibble),
    .glyph_o  (dec_glyph)
  );

  // Pins are driven from next-cycle state so every output is a flop yet tracks state_q.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == SHOW) begin
      if (snap_en_d[idx_d]) an_d[idx_d] = 1'b0;
      seg_d = dec_glyph;
      dp_d  = ~snap_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      snap_dp_q     <= '0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      snap_dp_q     <= snap_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with SLOT=10, BLANK_CYC=2, NUM_DIGITS=4.
module tb_seg_scan_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  digit_en_i = '0;
  logic [3:0]  dp_i = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  AN;
  logic        frame_done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  seg_scan_controller #(
    .CLK_HZ     (1000),
    .SCAN_HZ    (100),
    .BLANK_CYC  (2),
    .NUM_DIGITS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits_i   (digits_i),
    .digit_en_i (digit_en_i),
    .dp_i       (dp_i),
    .seg        (seg),
    .dp         (dp),
    .AN         (AN),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7:0] exp_an(input int s, input int pos, input logic [3:0] m);
    logic [7:0] one = 8'h01;
    if (pos < 2 || !m[s]) return 8'hFF;
    return ~(one << s);
  endfunction

  // Anodes must be all-off or exactly one active, every cycle.
  always @(negedge clk) begin
    if (!(AN == 8'hFF || $onehot(~AN))) begin
      n_bad++;
      $display("FAIL an_onehot: AN=%h required one-hot-low or FF", AN);
    end
  end

  task automatic restart(input logic [15:0] d, input logic [3:0] m, input logic [3:0] p);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    digits_i = d; digit_en_i = m; dp_i = p;
    en = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({AN, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_hold: AN=%h seg=%h dp=%b fd=%b required FF 7F 1 0", AN, seg, dp, frame_done);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({AN, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL idle_dark: cyc %0d AN=%h seg=%h dp=%b fd=%b required FF 7F 1 0", i, AN, seg, dp, frame_done);
      end
    end
  endtask

  task automatic test_scan;
    int s, pos;
    restart(16'h3210, 4'hF, 4'h0);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      s = ((k - 1) / 10) % 4; pos = (k - 1) % 10;
      n_cmp += 3;
      if (AN !== exp_an(s, pos, 4'hF)) begin
        n_bad++; $display("FAIL scan_an: k=%0d AN=%h required %h", k, AN, exp_an(s, pos, 4'hF));
      end
      if (seg !== ((pos < 2) ? 7'h7F : glyph(4'(s)))) begin
        n_bad++; $display("FAIL scan_seg: k=%0d seg=%b", k, seg);
      end
      if (frame_done !== (k == 41 || k == 81)) begin
        n_bad++; $display("FAIL scan_fd: k=%0d fd=%b required %b", k, frame_done, (k == 41 || k == 81));
      end
    end
  endtask

  task automatic test_snapshot;
    int s, pos;
    logic [3:0] nib;
    restart(16'h3210, 4'hF, 4'h0);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      s = ((k - 1) / 10) % 4; pos = (k - 1) % 10;
      nib = (k <= 40) ? 4'(s) : 4'h8;
      n_cmp += 2;
      if (seg !== ((pos < 2) ? 7'h7F : glyph(nib))) begin
        n_bad++; $display("FAIL snap_seg: k=%0d seg=%b required %b", k, seg, (pos < 2) ? 7'h7F : glyph(nib));
      end
      if (AN !== exp_an(s, pos, 4'hF)) begin
        n_bad++; $display("FAIL snap_an: k=%0d AN=%h required %h", k, AN, exp_an(s, pos, 4'hF));
      end
      if (k == 15) digits_i = 16'h8888;
    end
  endtask

  task automatic test_mask_dp;
    int s, pos;
    restart(16'h3210, 4'b1010, 4'b0010);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      s = ((k - 1) / 10) % 4; pos = (k - 1) % 10;
      n_cmp += 4;
      if (AN !== exp_an(s, pos, 4'b1010)) begin
        n_bad++; $display("FAIL mask_an: k=%0d AN=%h required %h", k, AN, exp_an(s, pos, 4'b1010));
      end
      if (dp !== !(pos >= 2 && s == 1)) begin
        n_bad++; $display("FAIL mask_dp: k=%0d dp=%b required %b", k, dp, !(pos >= 2 && s == 1));
      end
      if (seg !== ((pos < 2) ? 7'h7F : glyph(4'(s)))) begin
        n_bad++; $display("FAIL mask_seg: k=%0d seg=%b", k, seg);
      end
      if (frame_done !== (k == 41 || k == 81)) begin
        n_bad++; $display("FAIL mask_fd: k=%0d fd=%b", k, frame_done);
      end
    end
  endtask

  task automatic test_en_drop;
    restart(16'h3210, 4'hF, 4'h0);
    repeat (26) @(negedge clk);
    n_cmp++;
    if (AN !== 8'hFB) begin
      n_bad++; $display("FAIL drop_pre: AN=%h required FB", AN);
    end
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({AN, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL drop_dark: cyc %0d AN=%h seg=%h dp=%b fd=%b required FF 7F 1 0", i, AN, seg, dp, frame_done);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({AN, seg} !== ((k < 3) ? {8'hFF, 7'h7F} : {8'hFE, 7'b1000000})) begin
        n_bad++; $display("FAIL drop_resume: k=%0d AN=%h seg=%b", k, AN, seg);
      end
    end
  endtask

  task automatic test_async_reset;
    restart(16'h3210, 4'hF, 4'h0);
    repeat (15) @(negedge clk);
    n_cmp++;
    if (AN !== 8'hFD) begin
      n_bad++; $display("FAIL arst_pre: AN=%h required FD", AN);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({AN, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL arst_immediate: AN=%h seg=%h dp=%b fd=%b required FF 7F 1 0", AN, seg, dp, frame_done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      n_cmp++;
      if (AN !== exp_an(((k - 1) / 10) % 4, (k - 1) % 10, 4'hF)) begin
        n_bad++;
        $display("FAIL arst_resume: k=%0d AN=%h required %h", k, AN, exp_an(((k - 1) / 10) % 4, (k - 1) % 10, 4'hF));
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_snapshot;
    test_mask_dp;
    test_en_drop;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
